// File: rtl/cmd_clk_delay_pkg.sv
// cmd_clk_delay_pkg: widths, FSM states and the single-step rule for the command-clock delay controller.
// Scan states exist only when CMD_CLK_SCAN_EN is defined.
package cmd_clk_delay_pkg;
   localparam int CODE_W = 5;
   localparam int FINE_W = 4;
   localparam logic [FINE_W-1:0] MAX_FINE = 4'd15;
   typedef enum logic [2:0] {
      IDLE, EVAL, STEP, SETTLE
`ifdef CMD_CLK_SCAN_EN
      , SCAN_DWELL, SCAN_NEXT
`endif
   } cdc_state_e;
   // Phase may only flip while fine is 0, so a phase change first walks fine down.
   function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] cur, input logic [CODE_W-1:0] tgt);
      logic [FINE_W-1:0] f;
      f = cur[FINE_W-1:0];
      if (cur[FINE_W] != tgt[FINE_W]) return f != '0 ? {cur[FINE_W], f - 1'b1} : {~cur[FINE_W], f};
      if (tgt[FINE_W-1:0] > f) return {cur[FINE_W], f == MAX_FINE ? f : f + 1'b1};
      if (tgt[FINE_W-1:0] < f) return {cur[FINE_W], f == '0 ? f : f - 1'b1};
      return cur;
   endfunction
endpackage

// File: rtl/cmd_clk_delay_ctrl_if.sv
// cmd_clk_delay_ctrl_if: configuration, scan and stage-select signals of the command-clock delay controller.
interface cmd_clk_delay_ctrl_if;
   import cmd_clk_delay_pkg::*;
   logic              CfgPhase;
   logic [FINE_W-1:0] CfgFineDelay;
   logic              CfgLoad;
   logic              ScanStart;
   logic              AlignOk;
   logic              SelClkPhase;
   logic [FINE_W-1:0] ClkFineDelay;
   logic              Busy;
   logic              Done;
   logic [CODE_W-1:0] ScanBest;
   logic              ScanValid;
   modport master (
      output CfgPhase, CfgFineDelay, CfgLoad, ScanStart, AlignOk,
      input  SelClkPhase, ClkFineDelay, Busy, Done, ScanBest, ScanValid
   );
   modport slave (
      input  CfgPhase, CfgFineDelay, CfgLoad, ScanStart, AlignOk,
      output SelClkPhase, ClkFineDelay, Busy, Done, ScanBest, ScanValid
   );
endinterface

// File: rtl/cdc_cycle_counter.sv
// cdc_cycle_counter: loadable down-counter that stops at zero and flags terminal count.
module cdc_cycle_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else if (load) cnt_q <= load_val;
      else if (!tc) cnt_q <= cnt_q - 1'b1;
   assign tc = cnt_q == '0;
endmodule

// File: rtl/cmd_clk_delay_ctrl.sv
// cmd_clk_delay_ctrl: walks the command-clock phase/fine-delay selects one code at a time toward a target.
// Define CMD_CLK_SCAN_EN to add the 32-code alignment scan that parks at the centre of the widest passing window.
module cmd_clk_delay_ctrl
   import cmd_clk_delay_pkg::*;
#(
   parameter int SETTLE_CYCLES = 64,
   parameter int DWELL_CYCLES  = 1024
) (
   input logic                 CdrDelClk,
   input logic                 Reset,
   cmd_clk_delay_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2((SETTLE_CYCLES > DWELL_CYCLES ? SETTLE_CYCLES : DWELL_CYCLES) + 1);
   cdc_state_e state_q, state_d;
   logic [CODE_W-1:0] code_q, tgt_q, step_q, tgt_val;
   logic [CNT_W-1:0] cnt_val;
   logic cnt_load, cnt_tc, scan_go, sweep, tgt_set;
   cdc_cycle_counter #(.W(CNT_W)) u_cnt (
      .clk(CdrDelClk), .rst(Reset), .load(cnt_load), .load_val(cnt_val), .tc(cnt_tc)
   );
   assign bus.SelClkPhase  = code_q[FINE_W];
   assign bus.ClkFineDelay = code_q[FINE_W-1:0];
   assign bus.Busy         = state_q != IDLE;
   // Intermediate codes visited by a sweep are not completions.
   assign bus.Done         = state_q == EVAL && code_q == tgt_q && !sweep;
   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_val  = CNT_W'(SETTLE_CYCLES - 1);
      case (state_q)
         IDLE:   state_d = bus.CfgLoad || scan_go ? EVAL : IDLE;
         EVAL: begin
            if (code_q != tgt_q) state_d = STEP;
`ifdef CMD_CLK_SCAN_EN
            else if (sweep) begin
               state_d  = SCAN_DWELL;
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(DWELL_CYCLES - 1);
            end
`endif
            else state_d = bus.CfgLoad ? EVAL : IDLE;
         end
         STEP: begin
            state_d  = SETTLE;
            cnt_load = 1'b1;
         end
         SETTLE: state_d = cnt_tc ? EVAL : SETTLE;
`ifdef CMD_CLK_SCAN_EN
         SCAN_DWELL: state_d = cnt_tc ? SCAN_NEXT : SCAN_DWELL;
         SCAN_NEXT:  state_d = EVAL;
`endif
         default: state_d = IDLE;
      endcase
   end
   // The step is frozen in EVAL so a retarget during STEP still completes it.
   always_ff @(posedge CdrDelClk or posedge Reset)
      if (Reset) begin
         state_q <= IDLE;
         code_q  <= '0;
         tgt_q   <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == EVAL) step_q <= next_code(code_q, tgt_q);
         if (state_q == STEP) code_q <= step_q;
         if (bus.CfgLoad) tgt_q <= {bus.CfgPhase, bus.CfgFineDelay};
         else if (tgt_set) tgt_q <= tgt_val;
      end
`ifdef CMD_CLK_SCAN_EN
   logic [CODE_W-1:0] idx_q, pre_q, run_start_q, best_start_q, best_end_q, run_start_d;
   logic [CODE_W-1:0] best_s, best_e, mid, scan_best_q;
   logic [CODE_W:0] run_len_q, best_len_q, run_len_d, mid_sum;
   logic sweep_q, pass_q, better, found, last, scan_valid_q;
   assign scan_go       = bus.ScanStart && !bus.CfgLoad;
   assign sweep         = sweep_q;
   assign bus.ScanBest  = scan_best_q;
   assign bus.ScanValid = scan_valid_q;
   // Strictly-longer comparison keeps the first run on a tie.
   always_comb begin
      run_len_d   = pass_q ? run_len_q + 1'b1 : '0;
      run_start_d = run_len_q == '0 ? idx_q : run_start_q;
      better      = pass_q && run_len_d > best_len_q;
      best_s      = better ? run_start_d : best_start_q;
      best_e      = better ? idx_q : best_end_q;
      found       = better || best_len_q != '0;
      mid_sum     = {1'b0, best_s} + {1'b0, best_e};
      mid         = mid_sum[CODE_W:1];
      last        = idx_q == '1;
      tgt_set     = (state_q == IDLE && scan_go) || state_q == SCAN_NEXT;
      tgt_val     = state_q == IDLE ? '0 : !last ? idx_q + 1'b1 : found ? mid : pre_q;
   end
   always_ff @(posedge CdrDelClk or posedge Reset)
      if (Reset) begin
         sweep_q      <= 1'b0;
         pass_q       <= 1'b0;
         idx_q        <= '0;
         pre_q        <= '0;
         run_len_q    <= '0;
         run_start_q  <= '0;
         best_len_q   <= '0;
         best_start_q <= '0;
         best_end_q   <= '0;
         scan_best_q  <= '0;
         scan_valid_q <= 1'b0;
      end else if (state_q == IDLE && scan_go) begin
         sweep_q    <= 1'b1;
         idx_q      <= '0;
         pre_q      <= code_q;
         run_len_q  <= '0;
         best_len_q <= '0;
      end else if (state_q == EVAL) pass_q <= 1'b1;
      else if (state_q == SCAN_DWELL) pass_q <= pass_q & bus.AlignOk;
      else if (state_q == SCAN_NEXT) begin
         run_len_q   <= run_len_d;
         run_start_q <= run_start_d;
         idx_q       <= idx_q + 1'b1;
         if (better) begin
            best_len_q   <= run_len_d;
            best_start_q <= run_start_d;
            best_end_q   <= idx_q;
         end
         if (last) begin
            sweep_q      <= 1'b0;
            scan_valid_q <= found;
            scan_best_q  <= found ? mid : '0;
         end
      end
`else
   logic unused_scan;
   assign unused_scan   = bus.ScanStart ^ bus.AlignOk;
   assign scan_go       = 1'b0;
   assign sweep         = 1'b0;
   assign tgt_set       = 1'b0;
   assign tgt_val       = '0;
   assign bus.ScanBest  = '0;
   assign bus.ScanValid = 1'b0;
`endif
endmodule

// File: tb/tb_cmd_clk_delay_ctrl.sv
// tb_cmd_clk_delay_ctrl: every output code change is popped from a queue of expected single-step codes.
// Scan scenarios run only when CMD_CLK_SCAN_EN is defined.
module tb_cmd_clk_delay_ctrl;
   localparam int S = 4;
   localparam int D = 3;
   localparam int STEP_T = S + 2;
   logic clk = 1'b0;
   logic rst;
   cmd_clk_delay_ctrl_if bus();
   cmd_clk_delay_ctrl #(.SETTLE_CYCLES(S), .DWELL_CYCLES(D)) dut (.CdrDelClk(clk), .Reset(rst), .bus(bus));
   always #5 clk = ~clk;
   logic [4:0] exp_q[$];
   int chg_q[$];
   int errors = 0, checks = 0, cyc = 0, done_cnt = 0, done_cyc = -1, busy_low = 0;
   logic [4:0] prev = '0, cur = '0;
   bit align_mode = 1'b0;

   function automatic bit legal(input logic [4:0] a, input logic [4:0] b);
      logic [4:0] fa, fb;
      fa = {1'b0, a[3:0]};
      fb = {1'b0, b[3:0]};
      return (a[4] == b[4] && (fb == fa + 5'd1 || fa == fb + 5'd1)) || (a[4] != b[4] && fa == 5'd0 && fb == 5'd0);
   endfunction

   task automatic tick();
      logic [4:0] want;
      @(posedge clk);
      #1;
      cyc++;
      cur = {bus.SelClkPhase, bus.ClkFineDelay};
      if (bus.Done) begin done_cnt++; done_cyc = cyc; end
      if (!bus.Busy) busy_low++;
      if (cur !== prev) begin
         chg_q.push_back(cyc);
         checks++;
         if (!legal(prev, cur)) begin errors++; $display("FAIL single_step: %0d -> %0d is not a one-field one-LSB move", prev, cur); end
         checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL unexpected_step: got %0d, expected no change", cur); end
         else begin
            want = exp_q.pop_front();
            if (cur !== want) begin errors++; $display("FAIL step_value: got %0d, expected %0d", cur, want); end
         end
      end
      prev = cur;
      bus.AlignOk = align_mode && (cur inside {[5'd9:5'd14], 5'd20});
   endtask

   task automatic push_path(input logic [4:0] from, input logic [4:0] to);
      logic [4:0] c;
      c = from;
      for (int i = 0; i < 40 && c != to; i++) begin
         if (c[4] != to[4]) c = c[3:0] != 4'd0 ? c - 5'd1 : {~c[4], 4'd0};
         else c = to[3:0] > c[3:0] ? c + 5'd1 : c - 5'd1;
         exp_q.push_back(c);
      end
   endtask

   task automatic load(input logic [4:0] code, input bit scan, output int at);
      bus.CfgPhase = code[4];
      bus.CfgFineDelay = code[3:0];
      bus.CfgLoad = 1'b1;
      bus.ScanStart = scan;
      tick();
      bus.CfgLoad = 1'b0;
      bus.ScanStart = 1'b0;
      at = cyc;
   endtask

   task automatic wait_done(input int budget, input string name);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) tick();
      checks++;
      if (done_cnt == d0) begin errors++; $display("FAIL %s_timeout: no Done within %0d cycles", name, budget); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if (cur !== 5'd0) begin errors++; $display("FAIL reset_code: got %0d, expected 0", cur); end
      checks++;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b done=%b, expected 0 0", bus.Busy, bus.Done); end
      checks++;
      if (bus.ScanBest !== 5'd0 || bus.ScanValid !== 1'b0) begin errors++; $display("FAIL reset_scan: best=%0d valid=%b, expected 0 0", bus.ScanBest, bus.ScanValid); end
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_ramp();
      int n;
      bit ok;
      chg_q.delete();
      for (int i = 1; i <= 5; i++) exp_q.push_back(5'(i));
      load(5'd5, 1'b0, n);
      checks++;
      if (bus.Busy !== 1'b1) begin errors++; $display("FAIL ramp_busy: got %b, expected 1", bus.Busy); end
      wait_done(100, "ramp");
      checks++;
      if (done_cyc - n != 5 * STEP_T) begin errors++; $display("FAIL ramp_done_time: got n+%0d, expected n+%0d", done_cyc - n + 1, 5 * STEP_T + 1); end
      ok = chg_q.size() == 5 && chg_q[0] == n + 2;
      for (int i = 1; i < chg_q.size(); i++) if (chg_q[i] - chg_q[i-1] != STEP_T) ok = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL ramp_spacing: %0d changes, first at +%0d, expected 5 changes from +2 spaced %0d", chg_q.size(), chg_q.size() > 0 ? chg_q[0] - n : -1, STEP_T); end
      tick();
      checks++;
      if (bus.Busy !== 1'b0 || cur !== 5'd5) begin errors++; $display("FAIL ramp_end: busy=%b code=%0d, expected 0 5", bus.Busy, cur); end
   endtask

   task automatic test_phase_cross();
      int n;
      exp_q.push_back(5'd4);
      exp_q.push_back(5'd3);
      load(5'd3, 1'b0, n);
      wait_done(100, "down");
      tick();
      chg_q.delete();
      exp_q.push_back(5'd2); exp_q.push_back(5'd1); exp_q.push_back(5'd0);
      exp_q.push_back(5'd16); exp_q.push_back(5'd17); exp_q.push_back(5'd18);
      load(5'd18, 1'b0, n);
      wait_done(200, "cross");
      checks++;
      if (done_cyc - n != 6 * STEP_T || chg_q.size() != 6) begin errors++; $display("FAIL cross_steps: %0d changes, done at +%0d, expected 6 and +%0d", chg_q.size(), done_cyc - n, 6 * STEP_T); end
      tick();
      checks++;
      if (cur !== 5'd18 || exp_q.size() != 0) begin errors++; $display("FAIL cross_end: code=%0d pending=%0d, expected 18 0", cur, exp_q.size()); end
   endtask

   task automatic test_retarget();
      int n, d0;
      exp_q.push_back(5'd17); exp_q.push_back(5'd16); exp_q.push_back(5'd0);
      load(5'd0, 1'b0, n);
      wait_done(200, "home");
      tick();
      d0 = done_cnt;
      for (int i = 1; i <= 4; i++) exp_q.push_back(5'(i));
      load(5'd10, 1'b0, n);
      for (int i = 0; i < 100 && cur != 5'd4; i++) tick();
      checks++;
      if (cur !== 5'd4) begin errors++; $display("FAIL retarget_reach4: got %0d, expected 4", cur); end
      repeat (S) tick();
      exp_q.push_back(5'd5);
      for (int i = 4; i >= 1; i--) exp_q.push_back(5'(i));
      load(5'd1, 1'b0, n);
      wait_done(200, "retarget");
      repeat (10) tick();
      checks++;
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL retarget_done_count: got %0d, expected 1", done_cnt - d0); end
      checks++;
      if (cur !== 5'd1 || exp_q.size() != 0) begin errors++; $display("FAIL retarget_end: code=%0d pending=%0d, expected 1 0", cur, exp_q.size()); end
   endtask

   task automatic test_same_target();
      int n, d0;
      load(5'd1, 1'b1, n);
      d0 = done_cnt;
      checks++;
      if (done_cyc != n) begin errors++; $display("FAIL same_done: last Done at %0d, expected %0d", done_cyc, n); end
      tick();
      checks++;
      if (bus.Busy !== 1'b0 || cur !== 5'd1) begin errors++; $display("FAIL same_idle: busy=%b code=%0d, expected 0 1", bus.Busy, cur); end
      repeat (10) tick();
      checks++;
      if (bus.Busy !== 1'b0 || done_cnt != d0 || cur !== 5'd1) begin errors++; $display("FAIL no_scan: busy=%b extra_done=%0d code=%0d, expected 0 0 1", bus.Busy, done_cnt - d0, cur); end
   endtask

   task automatic test_reset_mid_settle();
      int n;
      for (int i = 2; i <= 7; i++) exp_q.push_back(5'(i));
      load(5'd7, 1'b0, n);
      for (int i = 0; i < 100 && cur != 5'd7; i++) tick();
      tick();
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.SelClkPhase, bus.ClkFineDelay} !== 5'd0) begin errors++; $display("FAIL async_reset_code: got %0d, expected 0", {bus.SelClkPhase, bus.ClkFineDelay}); end
      checks++;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin errors++; $display("FAIL async_reset_flags: busy=%b done=%b, expected 0 0", bus.Busy, bus.Done); end
      prev = '0;
      exp_q.delete();
      #1 rst = 1'b0;
      repeat (3) tick();
      checks++;
      if (bus.Busy !== 1'b0 || cur !== 5'd0) begin errors++; $display("FAIL post_reset: busy=%b code=%0d, expected 0 0", bus.Busy, cur); end
   endtask

`ifdef CMD_CLK_SCAN_EN
   task automatic run_scan(input logic [4:0] final_code, input bit valid, input string name);
      int d0, b0;
      push_path(cur, 5'd0);
      for (int i = 1; i < 32; i++) push_path(5'(i - 1), 5'(i));
      push_path(5'd31, final_code);
      bus.AlignOk = align_mode && (cur inside {[5'd9:5'd14], 5'd20});
      d0 = done_cnt;
      bus.ScanStart = 1'b1;
      tick();
      bus.ScanStart = 1'b0;
      b0 = busy_low;
      wait_done(5000, name);
      checks++;
      if (busy_low != b0) begin errors++; $display("FAIL %s_busy: Busy low %0d cycles during scan, expected 0", name, busy_low - b0); end
      repeat (5) tick();
      checks++;
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s_done_count: got %0d, expected 1", name, done_cnt - d0); end
      checks++;
      if (bus.ScanValid !== valid) begin errors++; $display("FAIL %s_valid: got %b, expected %b", name, bus.ScanValid, valid); end
      checks++;
      if (cur !== final_code || exp_q.size() != 0) begin errors++; $display("FAIL %s_end: code=%0d pending=%0d, expected %0d 0", name, cur, exp_q.size(), final_code); end
   endtask

   task automatic test_scan_pass();
      align_mode = 1'b1;
      run_scan(5'd11, 1'b1, "scan_pass");
      checks++;
      if (bus.ScanBest !== 5'd11) begin errors++; $display("FAIL scan_best: got %0d, expected 11", bus.ScanBest); end
   endtask

   task automatic test_scan_fail();
      align_mode = 1'b0;
      run_scan(5'd11, 1'b0, "scan_fail");
   endtask
`endif

   initial begin
      bus.CfgPhase = 1'b0;
      bus.CfgFineDelay = 4'd0;
      bus.CfgLoad = 1'b0;
      bus.ScanStart = 1'b0;
      bus.AlignOk = 1'b0;
      rst = 1'b1;
      test_reset();
      test_ramp();
      test_phase_cross();
      test_retarget();
      test_same_target();
      test_reset_mid_settle();
`ifdef CMD_CLK_SCAN_EN
      test_scan_pass();
      test_scan_fail();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cmd_clk_delay_ctrl.md
# cmd_clk_delay_ctrl

Sequencing controller for the 160 MHz command-clock phase/fine-delay stage. It owns the stage's `SelClkPhase` and `ClkFineDelay[3:0]` select inputs and moves them to a requested setting one code at a time, with a settle interval after each change, so the clock muxes never take a multi-bit select jump. An optional scan engine sweeps all 32 settings against an alignment flag and parks the stage at the centre of the widest passing window. It sits in the EOC clocking logic between the configuration registers and the phase/delay stage.

## Interface
Parameters:
- `SETTLE_CYCLES`, 64: clock cycles waited after every select change (≥1).
- `DWELL_CYCLES`, 1024: per-code observation window in scan (≥1).

Ports:
- `CdrDelClk`  in  1  controller clock; the same delay-line clock the stage uses.
- `Reset`  in  1  asynchronous, active-high reset.
- `CfgPhase`  in  1  requested phase select.
- `CfgFineDelay`  in  4  requested fine-delay code.
- `CfgLoad`  in  1  one-cycle pulse that captures `CfgPhase` and `CfgFineDelay` as the target.
- `ScanStart`  in  1  one-cycle pulse that starts a scan (see Configuration).
- `AlignOk`  in  1  alignment-good flag, sampled during scan dwell.
- `SelClkPhase`  out  1  registered phase select to the stage.
- `ClkFineDelay`  out  4  registered fine-delay select to the stage.
- `Busy`  out  1  high whenever the FSM is not in IDLE.
- `Done`  out  1  one-cycle pulse when the outputs have reached the target.
- `ScanBest`  out  5  {phase, fine} code chosen by the last scan.
- `ScanValid`  out  1  high when the last scan found a passing code.

## Operation
- Setting code = {phase, fine}, 5 bits. The current code is the output register pair.
- States: IDLE, EVAL, STEP, SETTLE, plus SCAN_DWELL and SCAN_NEXT when scan is compiled in.
- IDLE: `CfgLoad` loads the target and moves the FSM to EVAL.
- EVAL:
  - current == target: pulse `Done`, go to IDLE.
  - phase differs and fine ≠ 0: step fine toward 0.
  - phase differs and fine == 0: toggle phase.
  - phase equal: step fine by ±1 toward target.
  - Each case above goes to STEP.
- STEP: apply exactly one change to the output registers. Only one output bit-field changes per STEP. Go to SETTLE.
- SETTLE: count `SETTLE_CYCLES`, then go to EVAL.
- `CfgLoad` while `Busy`: the target is overwritten immediately. The step in progress completes. The next EVAL steers toward the new target. No extra `Done` is generated for the abandoned target.
- `CfgLoad` and `ScanStart` in the same IDLE cycle: `CfgLoad` wins, and `ScanStart` is dropped.
- `ScanStart` while `Busy`: ignored.
- Reset at any time returns all state to reset values within the same cycle (asynchronous). No partial step is retained.
- Fine-code arithmetic is 4-bit unsigned and saturating. It never wraps 15→0 or 0→15.

## Timing
- Reset values:
  - `SelClkPhase`=0, `ClkFineDelay`=0.
  - `Busy`=0, `Done`=0, `ScanBest`=0, `ScanValid`=0.
  - FSM in IDLE, target=0.
- `CfgLoad` sampled high at edge n:
  - `Busy`=1 from n+1.
  - First output change is visible after edge n+2 (EVAL at n+1, STEP at n+2).
- Each step costs `SETTLE_CYCLES`+2 cycles (EVAL, STEP, SETTLE).
- For k steps, `Done` is high during cycle n+1+k·(`SETTLE_CYCLES`+2), and `Busy` falls on the following edge.
- `CfgLoad` with target == current: `Done` is high in cycle n+1, with no output change.
- Outputs are fully registered, with no combinational path from inputs to outputs.

## Configuration
Macro `CMD_CLK_SCAN_EN`.

Defined:
- `ScanStart` in IDLE sweeps codes 0→31 in ascending order.
- Codes are reached through the normal EVAL/STEP/SETTLE path.
- At each code the block dwells `DWELL_CYCLES` cycles. A code passes if `AlignOk` was high for every dwell cycle.
- The block tracks the longest contiguous passing run; on a tie, the first run wins.
- Scan result with at least one passing code:
  - `ScanBest` = floor((runStart+runEnd)/2).
  - `ScanValid`=1.
  - The target is set to `ScanBest` and the block moves there.
- Scan result with no passing code:
  - `ScanValid`=0.
  - The target is set to the pre-scan code and the block moves back to it.
- `Done` pulses once, when the final code is reached.
- `Busy` stays high for the whole scan.

Not defined:
- `ScanStart` and `AlignOk` are ignored.
- `ScanBest`=0 and `ScanValid`=0 are constant.
- No scan states or dwell counter are generated.

## Structure
- Package `cmd_clk_delay_pkg`:
  - state enum `cdc_state_e`.
  - `CODE_W`=5, `FINE_W`=4, `MAX_FINE`=15.
  - function `next_code(cur, tgt)` returning the single-step successor.
- Sub-module `cdc_cycle_counter`: loadable down-counter with terminal-count flag, shared by SETTLE and SCAN_DWELL.

## Test plan
- Reset mid-SETTLE with outputs at {0,7} → all outputs read 0 in the same cycle; `Busy`=0.
- From {0,0}, `CfgLoad` {0,5}, `SETTLE_CYCLES`=4:
  - outputs step 1,2,3,4,5, six cycles apart.
  - `Done` in cycle n+31.
  - no change ever exceeds one LSB.
- From {0,3}, `CfgLoad` {1,2}:
  - fine ramps 3→0, then phase toggles, then fine ramps 0→2.
  - 6 steps total; phase changes only while fine==0.
- From {0,0}, `CfgLoad` {0,10}; while at fine=4, `CfgLoad` {0,1}:
  - the block completes the step to 5, then descends to 1.
  - exactly one `Done` pulse.
- `CfgLoad` target equal to current → `Done` at n+1, outputs unchanged; simultaneous `CfgLoad` and `ScanStart` → no scan.
- With `CMD_CLK_SCAN_EN`, `AlignOk` high only for codes 9–14 (also 20 alone):
  - `ScanBest`=11, `ScanValid`=1, outputs end at {0,11}.
  - With `AlignOk` always low: `ScanValid`=0 and outputs return to the pre-scan code.
